vga_mode_sequencer: RTL and testbench



---
 rtl/vga_pkg.sv | 24 ++
 rtl/button_debounce.sv | 47 ++++
 rtl/vga_mode_sequencer.sv | 129 ++++++++++++
 tb/tb_vga_mode_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared encodings and widths for the VGA display path.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_PATTERN = 2'd1,
        MODE_SNOW    = 2'd2,
        MODE_AUTO    = 2'd3
    } mode_e;

    localparam int COLOR_W      = 8;
    localparam int COORD_W      = 10;
    localparam int V_ACTIVE_DEF = 480;

    function automatic mode_e next_mode(mode_e m);
        case (m)
            MODE_SOLID:   return MODE_PATTERN;
            MODE_PATTERN: return MODE_SNOW;
            MODE_SNOW:    return MODE_AUTO;
            default:      return MODE_SOLID;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises a raw button, debounces it and emits a one-cycle pulse on
// each accepted rising edge. Releases produce no pulse.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;
    logic          press_q, press_d;
    logic          flip;

    // Counter only runs while the synchronised level disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_comb begin
        sync_d  = {sync_q[0], button_i};
        flip    = (sync_q[1] != deb_q) && (cnt_q == CNT_LAST);
        cnt_d   = (sync_q[1] == deb_q || flip) ? '0 : cnt_q + 1'b1;
        deb_d   = deb_q ^ flip;
        press_d = flip && !deb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/vga_mode_sequencer.sv
// Frame-synchronous display mode sequencer: debounced button advances the
// mode at frame boundaries, switches are latched per frame, pixels arbitrated.
module vga_mode_sequencer
    import vga_pkg::*;
#(
    parameter int                 DEBOUNCE_CYCLES = 250000,
    parameter int                 AUTO_FRAMES     = 60,
    parameter int                 V_ACTIVE        = V_ACTIVE_DEF,
    parameter logic [COLOR_W-1:0] TRANSPARENT     = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               button_i,
    input  logic [COLOR_W-1:0] switches_i,
    input  logic               req_i,
    input  logic [COORD_W-1:0] col_i,
    input  logic [COORD_W-1:0] row_i,
    input  logic [COLOR_W-1:0] pattern_color_i,
    input  logic [COLOR_W-1:0] snow_color_i,
    output logic [COLOR_W-1:0] color_out_o,
    output logic               color_valid_o,
    output logic [1:0]         mode_o,
    output logic [COLOR_W-1:0] cfg_switches_o,
    output logic               frame_tick_o
);

    localparam int ACW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [ACW-1:0]     AUTO_LAST = ACW'(AUTO_FRAMES - 1);
    localparam logic [COORD_W-1:0] V_ROW     = COORD_W'(V_ACTIVE);

    logic               press;
    mode_e              mode_q, mode_d;
    mode_e              auto_sel_q, auto_sel_d;
    logic [ACW-1:0]     auto_cnt_q, auto_cnt_d;
    logic               pending_q, pending_d;
    logic [COLOR_W-1:0] cfg_q, cfg_d;
    logic [COORD_W-1:0] row_q;
    logic               tick_q, tick_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               valid_q;
    mode_e              eff_mode;
    logic [COLOR_W-1:0] sel_color;

    // Sources own their spatial logic; the column is not needed here.
    logic unused_col;
    assign unused_col = ^col_i;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .button_i(button_i),
        .press_o (press)
    );

    assign tick_d = (row_i == V_ROW) && (row_q != V_ROW);

    always_comb begin
        mode_d     = mode_q;
        auto_sel_d = auto_sel_q;
        auto_cnt_d = auto_cnt_q;
        cfg_d      = cfg_q;
        if (tick_q) begin
            cfg_d = switches_i;
            if (pending_q) begin
                mode_d     = next_mode(mode_q);
                auto_cnt_d = '0;
                auto_sel_d = MODE_SOLID;
            end else if (mode_q == MODE_AUTO) begin
                if (auto_cnt_q == AUTO_LAST) begin
                    auto_cnt_d = '0;
                    auto_sel_d = (auto_sel_q == MODE_SNOW) ? MODE_SOLID : next_mode(auto_sel_q);
                end else begin
                    auto_cnt_d = auto_cnt_q + 1'b1;
                end
            end
        end
        // A press coinciding with the boundary survives into the next frame.
        if (press) begin
            pending_d = 1'b1;
        end else if (tick_q) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    always_comb begin
        eff_mode = (mode_q == MODE_AUTO) ? auto_sel_q : mode_q;
        case (eff_mode)
            MODE_SOLID:   sel_color = cfg_q;
            MODE_PATTERN: sel_color = pattern_color_i;
            default:      sel_color = (snow_color_i != TRANSPARENT) ? snow_color_i : pattern_color_i;
        endcase
        color_d = req_i ? sel_color : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_SOLID;
            auto_sel_q <= MODE_SOLID;
            auto_cnt_q <= '0;
            pending_q  <= 1'b0;
            cfg_q      <= '0;
            row_q      <= '0;
            tick_q     <= 1'b0;
            color_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            auto_sel_q <= auto_sel_d;
            auto_cnt_q <= auto_cnt_d;
            pending_q  <= pending_d;
            cfg_q      <= cfg_d;
            row_q      <= row_i;
            tick_q     <= tick_d;
            color_q    <= color_d;
            valid_q    <= req_i;
        end
    end

    assign color_out_o    = color_q;
    assign color_valid_o  = valid_q;
    assign mode_o         = mode_q;
    assign cfg_switches_o = cfg_q;
    assign frame_tick_o   = tick_q;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Bench for vga_mode_sequencer: directed sequences, an arbitration table and
// randomized traffic compared every cycle against a frame-level model.
module tb_vga_mode_sequencer;

    localparam int DEB = 4;
    localparam int AF  = 2;
    localparam int VA  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       button = 1'b0;
    logic [7:0] switches = 8'h00;
    logic       req = 1'b0;
    logic [9:0] col = 10'd0;
    logic [9:0] row = 10'd0;
    logic [7:0] pattern = 8'h00;
    logic [7:0] snow = 8'h00;
    logic [7:0] color_out;
    logic       color_valid;
    logic [1:0] mode;
    logic [7:0] cfg;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    vga_mode_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .AUTO_FRAMES    (AF),
        .V_ACTIVE       (VA),
        .TRANSPARENT    (8'h00)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .button_i       (button),
        .switches_i     (switches),
        .req_i          (req),
        .col_i          (col),
        .row_i          (row),
        .pattern_color_i(pattern),
        .snow_color_i   (snow),
        .color_out_o    (color_out),
        .color_valid_o  (color_valid),
        .mode_o         (mode),
        .cfg_switches_o (cfg),
        .frame_tick_o   (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the active edge.
    task automatic tick1();
        @(posedge clk);
        #2;
    endtask

    task automatic boundary();
        row = 10'd3;
        tick1();
        row = 10'(VA);
        tick1();
        tick1();
        row = 10'd0;
    endtask

    task automatic press_btn(input int hold);
        button = 1'b1;
        repeat (hold) tick1();
        button = 1'b0;
        repeat (8) tick1();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_color"}, color_out, 0);
        chk({tag, "_valid"}, color_valid, 0);
        chk({tag, "_mode"}, mode, 0);
        chk({tag, "_cfg"}, cfg, 0);
        chk({tag, "_tick"}, frame_tick, 0);
    endtask

    // ---------------- reference model (frame-level view) ----------------
    logic [5:0] m_hist  = '0;   // button samples, [0] = newest edge
    logic       m_deb   = 1'b0;
    logic       m_press = 1'b0;
    logic       m_tick  = 1'b0;
    logic       m_pend  = 1'b0;
    int         m_rowp  = 0;
    int         m_mode  = 0;
    int         m_frames = 0;   // frames spent in AUTO since entry
    logic [7:0] m_cfg   = 8'h00;
    logic [7:0] m_col   = 8'h00;
    logic       m_vld   = 1'b0;

    function automatic logic [7:0] pick(input int m, input int fr, input logic [7:0] c,
                                        input logic [7:0] p, input logic [7:0] s);
        int src;
        src = (m == 3) ? (fr / AF) % 3 : m;
        case (src)
            0:       return c;
            1:       return p;
            default: return (s != 8'h00) ? s : p;
        endcase
    endfunction

    initial forever begin
        logic flip;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_hist = '0; m_deb = 0; m_press = 0; m_tick = 0; m_pend = 0;
            m_rowp = 0; m_mode = 0; m_frames = 0; m_cfg = 0; m_col = 0; m_vld = 0;
        end else begin
            m_vld = req;
            m_col = req ? pick(m_mode, m_frames, m_cfg, pattern, snow) : 8'h00;
            if (m_tick) begin
                m_cfg = switches;
                if (m_pend) begin
                    m_mode   = (m_mode + 1) % 4;
                    m_frames = 0;
                end else if (m_mode == 3) begin
                    m_frames++;
                end
            end
            m_pend = m_press ? 1'b1 : (m_tick ? 1'b0 : m_pend);
            m_hist = {m_hist[4:0], button};
            // Accept a new level once four consecutive synchronised samples disagree.
            flip = (m_hist[2] != m_deb) && (m_hist[3] != m_deb) &&
                   (m_hist[4] != m_deb) && (m_hist[5] != m_deb);
            m_press = flip && !m_deb;
            m_deb   = m_deb ^ flip;
            m_tick  = (int'(row) == VA) && (m_rowp != VA);
            m_rowp  = int'(row);
        end
    end

    initial forever begin
        @(negedge clk);
        chk("mdl_color", color_out, m_col);
        chk("mdl_valid", color_valid, m_vld);
        chk("mdl_mode", mode, m_mode);
        chk("mdl_cfg", cfg, m_cfg);
        chk("mdl_tick", frame_tick, m_tick);
    end

    // ---------------- arbitration table (SNOW mode) ----------------
    typedef struct {
        logic       req;
        logic [7:0] pat;
        logic [7:0] snw;
        logic [7:0] exp_col;
        logic       exp_vld;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int r;
        tbl[0] = '{1'b1, 8'h1C, 8'h00, 8'h1C, 1'b1};
        tbl[1] = '{1'b1, 8'h1C, 8'hFF, 8'hFF, 1'b1};
        tbl[2] = '{1'b0, 8'h1C, 8'hFF, 8'h00, 1'b0};
        tbl[3] = '{1'b1, 8'hE3, 8'h00, 8'hE3, 1'b1};
        tbl[4] = '{1'b1, 8'h1C, 8'h80, 8'h80, 1'b1};

        #1;
        chk_reset_outputs("rst0");
        repeat (3) tick1();
        rst_n = 1'b1;
        tick1();

        // Config latch in SOLID mode
        req = 1'b1; switches = 8'hE0; row = 10'd1;
        tick1(); tick1();
        chk("cfg_old_mid", color_out, 8'h00);
        row = 10'd3; tick1();
        row = 10'(VA); tick1();
        chk("cfg_tick_hi", frame_tick, 1);
        tick1();
        chk("cfg_latched", cfg, 8'hE0);
        chk("cfg_tick_cycle_pixel", color_out, 8'h00);
        tick1();
        chk("cfg_new_color", color_out, 8'hE0);
        chk("cfg_new_valid", color_valid, 1);
        row = 10'd0;

        // Debounce
        button = 1'b1; repeat (3) tick1(); button = 1'b0;
        repeat (8) tick1();
        boundary();
        chk("glitch_no_adv", mode, 0);
        press_btn(10);
        chk("press_waits_frame", mode, 0);
        boundary();
        chk("press_adv", mode, 1);
        press_btn(6); press_btn(6); press_btn(6);
        boundary();
        chk("multi_press_one_adv", mode, 2);
        boundary();
        chk("multi_press_no_leftover", mode, 2);

        // SNOW arbitration table
        foreach (tbl[i]) begin
            req = tbl[i].req; pattern = tbl[i].pat; snow = tbl[i].snw;
            tick1();
            chk($sformatf("snow_vec%0d_color", i), color_out, tbl[i].exp_col);
            chk($sformatf("snow_vec%0d_valid", i), color_valid, tbl[i].exp_vld);
        end

        // AUTO cycling: SOLID x2, PATTERN x2, SNOW x2, SOLID
        req = 1'b1; pattern = 8'h1C; snow = 8'hFF; switches = 8'hE0;
        press_btn(6);
        boundary();
        begin
            logic [7:0] auto_exp [7];
            auto_exp = '{8'hE0, 8'hE0, 8'h1C, 8'h1C, 8'hFF, 8'hFF, 8'hE0};
            for (int f = 0; f < 7; f++) begin
                tick1();
                chk($sformatf("auto_mode_f%0d", f), mode, 3);
                chk($sformatf("auto_color_f%0d", f), color_out, auto_exp[f]);
                boundary();
            end
        end
        press_btn(6);
        boundary();
        chk("auto_exit", mode, 0);

        // Press pulse lands in the frame_tick cycle
        row = 10'd3; button = 1'b1;
        repeat (5) tick1();
        row = 10'(VA);
        tick1();
        chk("simul_tick", frame_tick, 1);
        tick1();
        chk("simul_no_adv", mode, 0);
        button = 1'b0; row = 10'd0;
        repeat (6) tick1();
        boundary();
        chk("simul_adv_next", mode, 1);

        // Reset mid-frame and mid-debounce
        req = 1'b1; row = 10'd2; button = 1'b1;
        tick1(); tick1(); tick1();
        chk("pre_rst_valid", color_valid, 1);
        rst_n = 1'b0; button = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        tick1(); tick1();
        rst_n = 1'b1;
        tick1();
        row = 10'd3; tick1();
        chk("post_rst_no_tick", frame_tick, 0);
        row = 10'(VA); tick1();
        chk("post_rst_first_tick", frame_tick, 1);
        tick1();
        chk("held_row_no_tick", frame_tick, 0);
        chk("rst_aborted_press", mode, 0);
        tick1();
        chk("held_row_no_tick2", frame_tick, 0);
        row = 10'd3; tick1();
        row = 10'd5; tick1(); tick1();
        chk("jump_row_no_tick", frame_tick, 0);

        // Randomized traffic against the model
        r = 0;
        for (int c = 0; c < 3000; c++) begin
            if ((c % 7) == 0) button = ($urandom_range(0, 3) == 0) ? ~button : button;
            req      = 1'($urandom_range(0, 3) != 0);
            pattern  = 8'($urandom);
            snow     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            switches = 8'($urandom);
            col      = 10'($urandom_range(0, 639));
            if ($urandom_range(0, 1) == 1) r = (r + (($urandom_range(0, 9) == 0) ? 2 : 1)) % 7;
            row = 10'(r);
            tick1();
        end

        tick1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
